// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared FSM state type and array-geometry helpers for the data-memory responder
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int line_width(input int nlines);
        return (nlines > 1) ? $clog2(nlines) : 1;
    endfunction

    function automatic int tag_width(input int depth, input int nlines);
        int w;
        w = idx_width(depth) - line_width(nlines);
        return (w > 0) ? w : 1;
    endfunction

endpackage

// File: rtl/dmem_if.sv
// rtl/dmem_if.sv - controller-to-memory load/store request bus with busy stall
interface dmem_if #(
    parameter int NBITS = 8
);
    logic             MemRead;
    logic             MemWrite;
    logic [NBITS-1:0] Address;
    logic [NBITS-1:0] WriteData;
    logic [NBITS-1:0] ReadData;
    logic             busy;

    modport master (
        output MemRead, MemWrite, Address, WriteData,
        input  ReadData, busy
    );

    modport slave (
        input  MemRead, MemWrite, Address, WriteData,
        output ReadData, busy
    );
endinterface

// File: rtl/dmem_cache_tags.sv
// rtl/dmem_cache_tags.sv - direct-mapped tag/valid/data store, built only with DMEM_CACHE_EN
`ifdef DMEM_CACHE_EN
module dmem_cache_tags
    import dmem_pkg::*;
#(
    parameter int NBITS  = 8,
    parameter int DEPTH  = 256,
    parameter int NLINES = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [idx_width(DEPTH)-1:0]  lookup_idx_i,
    output logic                         hit_o,
    output logic [NBITS-1:0]             hit_data_o,
    input  logic                         fill_en_i,
    input  logic [idx_width(DEPTH)-1:0]  fill_idx_i,
    input  logic [NBITS-1:0]             fill_data_i
);
    localparam int IW = idx_width(DEPTH);
    localparam int LW = line_width(NLINES);
    localparam int TW = tag_width(DEPTH, NLINES);

    logic [NLINES-1:0] valid_q;
    logic [TW-1:0]     tag_q  [NLINES];
    logic [NBITS-1:0]  data_q [NLINES];

    logic [LW-1:0] lk_line, fl_line;
    logic [TW-1:0] lk_tag,  fl_tag;

    assign lk_line = lookup_idx_i[LW-1:0];
    assign lk_tag  = lookup_idx_i[IW-1:LW];
    assign fl_line = fill_idx_i[LW-1:0];
    assign fl_tag  = fill_idx_i[IW-1:LW];

    assign hit_o      = valid_q[lk_line] && (tag_q[lk_line] == lk_tag);
    assign hit_data_o = data_q[lk_line];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else if (fill_en_i) begin
            valid_q[fl_line] <= 1'b1;
        end
    end

    // Tag and data need no reset: they are ignored until the valid bit is set.
    always_ff @(posedge clock) begin
        if (fill_en_i) begin
            tag_q[fl_line]  <= fl_tag;
            data_q[fl_line] <= fill_data_i;
        end
    end
endmodule
`endif

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with LATENCY wait states on busy
// Optional direct-mapped read cache enabled by macro DMEM_CACHE_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int NBITS   = 8,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 3,
    parameter int NLINES  = 4
) (
    input logic  clock,
    input logic  reset,
    dmem_if.slave bus
);
    localparam int  IW       = idx_width(DEPTH);
    localparam int  CW       = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;
    localparam bit  ZERO_LAT = (LATENCY == 0);

    if ((NLINES < 1) || ((NLINES & (NLINES - 1)) != 0)) begin : g_bad_nlines
        $error("dmem_responder: NLINES must be a power of 2");
    end

    logic [NBITS-1:0] mem_q [DEPTH];

    dmem_state_t      state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_c, commit_c;
    logic [NBITS-1:0] rdata_c;

    logic [IW-1:0] idx;
    logic          req, is_store, is_load;

    assign idx      = bus.Address[IW-1:0];
    assign req      = bus.MemRead | bus.MemWrite;
    assign is_store = bus.MemWrite;
    assign is_load  = bus.MemRead & ~bus.MemWrite;

    logic             cache_hit;
    logic [NBITS-1:0] cache_data;

`ifdef DMEM_CACHE_EN
    dmem_cache_tags #(
        .NBITS (NBITS),
        .DEPTH (DEPTH),
        .NLINES(NLINES)
    ) u_cache (
        .clock       (clock),
        .reset       (reset),
        .lookup_idx_i(idx),
        .hit_o       (cache_hit),
        .hit_data_o  (cache_data),
        .fill_en_i   (reset && (state_q == DONE) && req),
        .fill_idx_i  (idx),
        .fill_data_i (is_store ? bus.WriteData : mem_q[idx])
    );
`else
    assign cache_hit  = 1'b0;
    assign cache_data = '0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_c   = 1'b0;
        commit_c = 1'b0;
        rdata_c  = '0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (ZERO_LAT) begin
                        commit_c = is_store;
                        rdata_c  = is_load ? mem_q[idx] : '0;
                    end else if (is_load && cache_hit) begin
                        rdata_c = cache_data;
                    end else begin
                        busy_c  = 1'b1;
                        cnt_d   = CW'(LATENCY - 1);
                        state_d = (LATENCY <= 1) ? DONE : WAIT;
                    end
                end
            end
            WAIT: begin
                busy_c = 1'b1;
                if (!req) begin
                    state_d = IDLE;
                end else begin
                    // Counter reaching zero after this decrement means the next cycle completes.
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_d = DONE;
                end
            end
            DONE: begin
                state_d  = IDLE;
                commit_c = is_store;
                rdata_c  = is_load ? mem_q[idx] : '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Storage is never cleared; a store arriving while reset is asserted is dropped.
    always_ff @(posedge clock) begin
        if (commit_c && reset) mem_q[idx] <= bus.WriteData;
    end

    assign bus.busy     = busy_c & reset;
    assign bus.ReadData = reset ? rdata_c : '0;
endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder (LATENCY 3 and 0)
module tb_dmem_responder;
    logic clock;
    logic reset;
    int   n_tests;
    int   n_fail;

`ifdef DMEM_CACHE_EN
    localparam int HIT_BUSY = 0;
`else
    localparam int HIT_BUSY = 3;
`endif

    dmem_if #(.NBITS(8)) bus3 ();
    dmem_if #(.NBITS(8)) bus0 ();

    dmem_responder #(.NBITS(8), .DEPTH(256), .LATENCY(3), .NLINES(4)) u_dut3 (
        .clock(clock), .reset(reset), .bus(bus3)
    );

    dmem_responder #(.NBITS(8), .DEPTH(16), .LATENCY(0), .NLINES(4)) u_dut0 (
        .clock(clock), .reset(reset), .bus(bus0)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic do_access(input logic rd, input logic wr, input logic [7:0] a,
                             input logic [7:0] d, output int nbusy, output logic [7:0] rdata);
        bit done;
        done  = 1'b0;
        nbusy = 0;
        rdata = 8'hxx;
        bus3.MemRead = rd; bus3.MemWrite = wr; bus3.Address = a; bus3.WriteData = d;
        for (int i = 0; i < 10 && !done; i++) begin
            @(negedge clock);
            if (bus3.busy) begin
                nbusy++;
                @(posedge clock); #1;
            end else begin
                rdata = bus3.ReadData;
                done  = 1'b1;
            end
        end
        if (!done) nbusy = 99;
        @(posedge clock); #1;
        bus3.MemRead = 1'b0; bus3.MemWrite = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus3.MemRead = 1'b1; bus3.Address = 8'h10;
        @(negedge clock);
        n_tests++; if (bus3.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy3 got %b want 0", bus3.busy); end
        n_tests++; if (bus3.ReadData !== 8'h00) begin n_fail++; $display("FAIL reset_rdata3 got %h want 00", bus3.ReadData); end
        n_tests++; if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy0 got %b want 0", bus0.busy); end
        n_tests++; if (bus0.ReadData !== 8'h00) begin n_fail++; $display("FAIL reset_rdata0 got %h want 00", bus0.ReadData); end
        bus3.MemRead = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic test_store_load();
        int nb; logic [7:0] rd;
        do_access(1'b0, 1'b1, 8'h10, 8'h5A, nb, rd);
        n_tests++; if (nb !== 3) begin n_fail++; $display("FAIL store_busy got %0d want 3", nb); end
        n_tests++; if (rd !== 8'h00) begin n_fail++; $display("FAIL store_rdata got %h want 00", rd); end
        do_access(1'b1, 1'b0, 8'h10, 8'h00, nb, rd);
        n_tests++; if (nb !== HIT_BUSY) begin n_fail++; $display("FAIL load_busy got %0d want %0d", nb, HIT_BUSY); end
        n_tests++; if (rd !== 8'h5A) begin n_fail++; $display("FAIL load_rdata got %h want 5a", rd); end
    endtask

    task automatic test_zero_latency();
        bus0.MemWrite = 1'b1; bus0.MemRead = 1'b0; bus0.Address = 8'h20; bus0.WriteData = 8'h11;
        @(negedge clock);
        n_tests++; if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL lat0_store_busy got %b want 0", bus0.busy); end
        @(posedge clock); #1;
        bus0.MemWrite = 1'b0; bus0.MemRead = 1'b1;
        @(negedge clock);
        n_tests++; if (bus0.busy !== 1'b0) begin n_fail++; $display("FAIL lat0_load_busy got %b want 0", bus0.busy); end
        n_tests++; if (bus0.ReadData !== 8'h11) begin n_fail++; $display("FAIL lat0_load got %h want 11", bus0.ReadData); end
        @(posedge clock); #1;
        bus0.Address = 8'h00;
        @(negedge clock);
        n_tests++; if (bus0.ReadData !== 8'h11) begin n_fail++; $display("FAIL lat0_wrap got %h want 11", bus0.ReadData); end
        @(posedge clock); #1;
        bus0.MemRead = 1'b0;
        @(negedge clock);
        n_tests++; if (bus0.ReadData !== 8'h00) begin n_fail++; $display("FAIL lat0_idle_rdata got %h want 00", bus0.ReadData); end
        @(posedge clock); #1;
    endtask

    task automatic test_reset_in_wait();
        int nb; logic [7:0] rd;
        do_access(1'b0, 1'b1, 8'h08, 8'hA5, nb, rd);
        bus3.MemWrite = 1'b1; bus3.Address = 8'h08; bus3.WriteData = 8'h33;
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        n_tests++; if (bus3.busy !== 1'b0) begin n_fail++; $display("FAIL rst_wait_busy got %b want 0", bus3.busy); end
        n_tests++; if (bus3.ReadData !== 8'h00) begin n_fail++; $display("FAIL rst_wait_rdata got %h want 00", bus3.ReadData); end
        @(posedge clock); #1;
        bus3.MemWrite = 1'b0;
        reset = 1'b1;
        @(posedge clock); #1;
        do_access(1'b1, 1'b0, 8'h08, 8'h00, nb, rd);
        n_tests++; if (nb !== 3) begin n_fail++; $display("FAIL rst_wait_load_busy got %0d want 3", nb); end
        n_tests++; if (rd !== 8'hA5) begin n_fail++; $display("FAIL rst_wait_kept got %h want a5", rd); end
    endtask

    task automatic test_both_flags();
        int nb; logic [7:0] rd;
        do_access(1'b0, 1'b1, 8'h04, 8'h99, nb, rd);
        do_access(1'b1, 1'b1, 8'h04, 8'h7E, nb, rd);
        n_tests++; if (nb !== 3) begin n_fail++; $display("FAIL both_busy got %0d want 3", nb); end
        n_tests++; if (rd !== 8'h00) begin n_fail++; $display("FAIL both_rdata got %h want 00", rd); end
        do_access(1'b1, 1'b0, 8'h04, 8'h00, nb, rd);
        n_tests++; if (rd !== 8'h7E) begin n_fail++; $display("FAIL both_stored got %h want 7e", rd); end
    endtask

    task automatic test_abort();
        int nb; logic [7:0] rd;
        do_access(1'b0, 1'b1, 8'h30, 8'h22, nb, rd);
        bus3.MemWrite = 1'b1; bus3.Address = 8'h30; bus3.WriteData = 8'hEE;
        @(posedge clock); #1;
        @(posedge clock); #1;
        bus3.MemWrite = 1'b0;
        @(posedge clock); #1;
        @(negedge clock);
        n_tests++; if (bus3.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", bus3.busy); end
        @(posedge clock); #1;
        do_access(1'b1, 1'b0, 8'h30, 8'h00, nb, rd);
        n_tests++; if (nb !== HIT_BUSY) begin n_fail++; $display("FAIL abort_load_busy got %0d want %0d", nb, HIT_BUSY); end
        n_tests++; if (rd !== 8'h22) begin n_fail++; $display("FAIL abort_no_store got %h want 22", rd); end
    endtask

    task automatic test_back_to_back();
        int nb; logic [7:0] rd;
        logic exp_busy;
        bus3.MemWrite = 1'b1; bus3.Address = 8'h50; bus3.WriteData = 8'h66;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            exp_busy = ((i % 4) != 3);
            n_tests++;
            if (bus3.busy !== exp_busy) begin
                n_fail++; $display("FAIL b2b_busy[%0d] got %b want %b", i, bus3.busy, exp_busy);
            end
            @(posedge clock); #1;
        end
        bus3.MemWrite = 1'b0;
        do_access(1'b1, 1'b0, 8'h50, 8'h00, nb, rd);
        n_tests++; if (rd !== 8'h66) begin n_fail++; $display("FAIL b2b_load got %h want 66", rd); end
    endtask

`ifdef DMEM_CACHE_EN
    task automatic test_cache();
        int nb1, nb2; logic [7:0] rd1, rd2;
        do_access(1'b1, 1'b0, 8'h40, 8'h00, nb1, rd1);
        n_tests++; if (nb1 !== 3) begin n_fail++; $display("FAIL cache_miss_busy got %0d want 3", nb1); end
        do_access(1'b1, 1'b0, 8'h40, 8'h00, nb2, rd2);
        n_tests++; if (nb2 !== 0) begin n_fail++; $display("FAIL cache_hit_busy got %0d want 0", nb2); end
        n_tests++; if (rd2 !== rd1) begin n_fail++; $display("FAIL cache_hit_data got %h want %h", rd2, rd1); end
        do_access(1'b0, 1'b1, 8'h40, 8'hC7, nb1, rd1);
        n_tests++; if (nb1 !== 3) begin n_fail++; $display("FAIL cache_store_busy got %0d want 3", nb1); end
        do_access(1'b1, 1'b0, 8'h40, 8'h00, nb2, rd2);
        n_tests++; if (nb2 !== 0) begin n_fail++; $display("FAIL cache_upd_busy got %0d want 0", nb2); end
        n_tests++; if (rd2 !== 8'hC7) begin n_fail++; $display("FAIL cache_upd_data got %h want c7", rd2); end
    endtask
`endif

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        bus3.MemRead = 1'b0; bus3.MemWrite = 1'b0; bus3.Address = '0; bus3.WriteData = '0;
        bus0.MemRead = 1'b0; bus0.MemWrite = 1'b0; bus0.Address = '0; bus0.WriteData = '0;
        @(posedge clock); #1;
        test_reset();
        test_store_load();
        test_zero_latency();
        test_reset_in_wait();
        test_both_flags();
        test_abort();
        test_back_to_back();
`ifdef DMEM_CACHE_EN
        test_cache();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
